// File: rtl/demux_router.sv
// Four-channel demultiplexing router: one input stream is steered to one of
// four registered output channels, each with its own valid/ready handshake.
module demux_router #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               scan_mode,
  input  logic [1:0]         in_sel,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [1:0]         active_sel,
  output logic [CNT_W-1:0]   xfer_count
);

  logic [1:0] scan_ptr;
  logic       accept;
  logic [3:0] accept_vec;

  assign active_sel = scan_mode ? scan_ptr : in_sel;

  // A channel can take a word when it is empty or is being drained this cycle.
  assign in_ready = enable & (~out_valid[active_sel] | out_ready[active_sel]);
  assign accept   = in_valid & in_ready;

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no latch can be inferred on any path.
  always_comb begin
    accept_vec = '0;
    for (int n = 0; n < 4; n++) begin
      accept_vec[n] = accept && (active_sel == 2'(n));
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values. The data registers are reset too: a reset must discard
  // any held words, not just invalidate them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= '0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (accept_vec[n]) begin
          out_data[n*WIDTH +: WIDTH] <= in_data;
          out_valid[n]               <= 1'b1;
        end else if (out_ready[n]) begin
          out_valid[n] <= 1'b0;
        end
      end
    end
  end

  // Pointer advances only on accepts made in scan mode; mode changes leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_ptr <= 2'd0;
    end else if (accept && scan_mode) begin
      scan_ptr <= scan_ptr + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count <= '0;
    end else if (accept && (xfer_count != {CNT_W{1'b1}})) begin
      xfer_count <= xfer_count + CNT_W'(1);
    end
  end

endmodule

// File: doc/demux_router.md
DEMUX_ROUTER -- requirements
Module: demux_router

Interface
REQ-001 Parameter: WIDTH, default 4, data width per channel.
REQ-002 Parameter: CNT_W, default 8, accepted-transfer counter width.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: enable  input  1  global enable; low blocks new input transfers.
REQ-006 Port: scan_mode  input  1  1 = internal round-robin pointer selects the channel; 0 = in_sel selects it.
REQ-007 Port: in_sel  input  2  channel select when scan_mode=0: 0=A, 1=B, 2=C, 3=D.
REQ-008 Port: in_data  input  WIDTH  input word.
REQ-009 Port: in_valid  input  1  input word present.
REQ-010 Port: in_ready  output  1  block can accept in_data this cycle.
REQ-011 Port: out_data  output  4*WIDTH  packed channel registers; channel 0 (A) in bits [WIDTH-1:0], channel 3 (D) in the MSBs.
REQ-012 Port: out_valid  output  4  per-channel valid; bit n belongs to channel n.
REQ-013 Port: out_ready  input  4  per-channel consumer ready.
REQ-014 Port: active_sel  output  2  effective select this cycle.
REQ-015 Port: xfer_count  output  CNT_W  count of accepted input transfers.

Function
REQ-016 active_sel SHALL be combinational: scan_ptr when scan_mode=1, otherwise in_sel.
REQ-017 in_ready SHALL be combinational: enable AND (NOT out_valid[s] OR out_ready[s]), with s = active_sel.
REQ-018 Accept condition: in_valid AND in_ready at a rising edge.
REQ-019 On accept, the channel-s slice of out_data SHALL load in_data and out_valid[s] SHALL be 1 from the next cycle; latency is 1 clock.
REQ-020 Drain: when out_valid[n] AND out_ready[n] and no accept targets n in the same cycle, out_valid[n] SHALL clear next cycle.
REQ-021 Simultaneous drain and accept on the same channel: new data SHALL load, out_valid[n] SHALL stay 1, and no bubble SHALL occur.
REQ-022 Each channel SHALL drain independently; accepts on one channel SHALL NOT affect the others.
REQ-023 An out_data slice SHALL hold its last value after out_valid clears, and SHALL change only on an accept to that channel.
REQ-024 scan_ptr SHALL increment by 1 on each accept while scan_mode=1 and wrap 3->0; it SHALL hold otherwise.
REQ-025 Toggling scan_mode SHALL NOT modify scan_ptr.
REQ-026 xfer_count SHALL increment by 1 on each accept and saturate at 2^CNT_W-1.
REQ-027 When enable=0, in_ready SHALL be 0 and no accept SHALL occur, while channel drains SHALL continue per REQ-020.
REQ-028 in_data SHALL be ignored whenever in_valid=0.

Reset
REQ-029 When rst_n=0, out_data SHALL be 0, out_valid SHALL be 4'b0000, scan_ptr SHALL be 0, and xfer_count SHALL be 0, all immediately and without waiting for clk.
REQ-030 A reset asserted mid-transfer SHALL discard all held data; the first accept after release SHALL behave as if from power-up.
REQ-031 rst_n release SHALL be applied synchronously to clk by the bench; the first edge with rst_n=1 may accept data.

Verification
REQ-032 Directed routing: scan_mode=0, out_ready=4'b1111, sel=0..3 with data 4'h1,4'h2,4'h3,4'h4 on consecutive cycles -> each out_valid bit pulses for one cycle with the matching slice, and xfer_count=4.
REQ-033 Backpressure: out_ready=0, in_sel=2, two words 4'hA then 4'hB -> 4'hA is accepted; in_ready=0 on the next cycle and 4'hB is held; after out_ready[2]=1, 4'hB is accepted with no bubble per REQ-021.
REQ-034 Scan mode: scan_mode=1, out_ready=4'b1111, six accepts of data 0..5 -> channels A,B,C,D,A,B receive them in order, and scan_ptr wraps to 2.
REQ-035 Enable gating: enable=0 with in_valid=1 and channel B valid with out_ready[1]=1 -> in_ready=0, xfer_count is unchanged, and out_valid[1] clears.
REQ-036 Async reset: assert rst_n=0 between clock edges while out_valid=4'b0101 -> out_valid=0, out_data=0, and xfer_count=0 before the next edge.
REQ-037 Saturation: CNT_W=2 and 5 accepts -> xfer_count holds at 3.
